// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter for the shared 256-bit data memory
//
// Purpose:
//   Shares one line-wide data memory between the instruction cache (port 0)
//   and the data cache (port 1). One port is granted at a time, and the grant
//   is held until the memory acknowledges the transaction. Ties are broken
//   round-robin. A watchdog ends any grant that stays open too long without
//   an acknowledge and raises a sticky error flag.
//
// Parameters:
//   TIMEOUT  maximum cycles a grant may stay open without mem_ack_i (2..1023)
//   CNT_W    watchdog counter width; 2**CNT_W must exceed TIMEOUT
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   pX_enable_i / pX_write_i      port request and direction (1 = line write)
//   pX_addr_i / pX_data_i         line address and write line of port X
//   pX_data_o                     read line of port X (always mem_data_i)
//   pX_ack_o                      transaction done for port X
//   mem_enable_o / mem_write_o    request and direction to the memory
//   mem_addr_o / mem_data_o       address and write line to the memory
//   mem_data_i / mem_ack_i        read line and one-cycle ack from the memory
//   grant_o                       one-hot current grant, bit 0 = port 0
//   timeout_o                     sticky watchdog error

module mem_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,

    input  logic         p0_enable_i,
    input  logic         p0_write_i,
    input  logic [31:0]  p0_addr_i,
    input  logic [255:0] p0_data_i,
    output logic [255:0] p0_data_o,
    output logic         p0_ack_o,

    input  logic         p1_enable_i,
    input  logic         p1_write_i,
    input  logic [31:0]  p1_addr_i,
    input  logic [255:0] p1_data_i,
    output logic [255:0] p1_data_o,
    output logic         p1_ack_o,

    output logic         mem_enable_o,
    output logic         mem_write_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i,

    output logic [1:0]   grant_o,
    output logic         timeout_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2,
        TURN   = 2'd3
    } state_t;

    // Counter value seen in the last cycle a grant may remain open.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;

    logic             in_grant0;
    logic             in_grant1;
    logic             granted_enable;

    assign in_grant0 = (state_q == GRANT0);
    assign in_grant1 = (state_q == GRANT1);

    // Enable of whichever port currently holds the grant.
    assign granted_enable = (in_grant0 & p0_enable_i) | (in_grant1 & p1_enable_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;

        unique case (state_q)
            IDLE: begin
                // On a tie, port 0 wins only if port 1 was served last.
                if (p0_enable_i && (!p1_enable_i || last_q)) begin
                    state_d    = GRANT0;
                    last_d     = 1'b0;
                    wait_cnt_d = '0;
                end else if (p1_enable_i) begin
                    state_d    = GRANT1;
                    last_d     = 1'b1;
                    wait_cnt_d = '0;
                end
            end

            GRANT0, GRANT1: begin
                // The ack wins over an abort or a watchdog expiry in the same cycle.
                if (mem_ack_i) begin
                    state_d = TURN;
                end else if (!granted_enable) begin
                    state_d = TURN;
                end else if (wait_cnt_q == LAST_CNT) begin
                    state_d   = TURN;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            TURN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory-side mux: only the granted port reaches the memory; all zero otherwise.
    always_comb begin
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        if (in_grant0) begin
            mem_enable_o = p0_enable_i;
            mem_write_o  = p0_write_i;
            mem_addr_o   = p0_addr_i;
            mem_data_o   = p0_data_i;
        end else if (in_grant1) begin
            mem_enable_o = p1_enable_i;
            mem_write_o  = p1_write_i;
            mem_addr_o   = p1_addr_i;
            mem_data_o   = p1_data_i;
        end
    end

    // Ack is forwarded with zero latency, and only to the granted port.
    // An ack arriving in TURN or IDLE (e.g. after an abort) is dropped.
    assign p0_ack_o  = in_grant0 & mem_ack_i;
    assign p1_ack_o  = in_grant1 & mem_ack_i;

    assign p0_data_o = mem_data_i;
    assign p1_data_o = mem_data_i;

    assign grant_o   = {in_grant1, in_grant0};
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter

module tb_mem_arbiter;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_i;
    logic         p0_enable_i, p0_write_i, p1_enable_i, p1_write_i;
    logic [31:0]  p0_addr_i, p1_addr_i;
    logic [255:0] p0_data_i, p1_data_i, mem_data_i;
    logic         mem_ack_i;

    logic [255:0] p0_data_o, p1_data_o, mem_data_o;
    logic         p0_ack_o, p1_ack_o, mem_enable_o, mem_write_o, timeout_o;
    logic [31:0]  mem_addr_o;
    logic [1:0]   grant_o;

    logic [255:0] wd_p0_data_o, wd_p1_data_o, wd_mem_data_o;
    logic         wd_p0_ack_o, wd_p1_ack_o, wd_mem_enable_o, wd_mem_write_o, wd_timeout_o;
    logic [31:0]  wd_mem_addr_o;
    logic [1:0]   wd_grant_o;

    mem_arbiter dut (
        .clk_i(clk), .rst_i(rst_i),
        .p0_enable_i(p0_enable_i), .p0_write_i(p0_write_i), .p0_addr_i(p0_addr_i),
        .p0_data_i(p0_data_i), .p0_data_o(p0_data_o), .p0_ack_o(p0_ack_o),
        .p1_enable_i(p1_enable_i), .p1_write_i(p1_write_i), .p1_addr_i(p1_addr_i),
        .p1_data_i(p1_data_i), .p1_data_o(p1_data_o), .p1_ack_o(p1_ack_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    mem_arbiter #(.TIMEOUT(8), .CNT_W(4)) dut_wd (
        .clk_i(clk), .rst_i(rst_i),
        .p0_enable_i(p0_enable_i), .p0_write_i(p0_write_i), .p0_addr_i(p0_addr_i),
        .p0_data_i(p0_data_i), .p0_data_o(wd_p0_data_o), .p0_ack_o(wd_p0_ack_o),
        .p1_enable_i(p1_enable_i), .p1_write_i(p1_write_i), .p1_addr_i(p1_addr_i),
        .p1_data_i(p1_data_i), .p1_data_o(wd_p1_data_o), .p1_ack_o(wd_p1_ack_o),
        .mem_enable_o(wd_mem_enable_o), .mem_write_o(wd_mem_write_o), .mem_addr_o(wd_mem_addr_o),
        .mem_data_o(wd_mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
        .grant_o(wd_grant_o), .timeout_o(wd_timeout_o)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        p0_enable_i = 1'b0; p0_write_i = 1'b0; p0_addr_i = '0; p0_data_i = '0;
        p1_enable_i = 1'b0; p1_write_i = 1'b0; p1_addr_i = '0; p1_data_i = '0;
        mem_data_i  = '0;   mem_ack_i  = 1'b0;
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        #1;
    endtask

    localparam logic [255:0] RD_LINE = {8{32'hC0DE_0001}};
    localparam logic [255:0] WR_LINE = {4{64'h1234_5678_9ABC_DEF0}};
    localparam logic [255:0] RD_LINE2 = {16{16'h5AA5}};

    initial begin
        // Reset state
        do_reset();
        check("rst_grant",   grant_o, 2'b00);
        check("rst_menable", mem_enable_o, 1'b0);
        check("rst_timeout", timeout_o, 1'b0);
        check("rst_acks",    {p0_ack_o, p1_ack_o}, 2'b00);
        check("rst_maddr",   mem_addr_o, 32'h0);

        // Single read on port 1, memory acks 10 cycles after enable
        p1_enable_i = 1'b1; p1_addr_i = 32'h0000_0100;
        #1;
        check("t1_idle_grant", grant_o, 2'b00);
        tick(); #1;
        check("t1_grant",   grant_o, 2'b10);
        check("t1_menable", mem_enable_o, 1'b1);
        check("t1_maddr",   mem_addr_o, 32'h0000_0100);
        check("t1_mwrite",  mem_write_o, 1'b0);
        for (int i = 0; i < 8; i++) tick();
        #1;
        check("t1_noack_early", p1_ack_o, 1'b0);
        tick();
        mem_ack_i = 1'b1; mem_data_i = RD_LINE;
        #1;
        check("t1_p1_ack",  p1_ack_o, 1'b1);
        check("t1_p0_ack",  p0_ack_o, 1'b0);
        check("t1_p1_data", p1_data_o, RD_LINE);
        check("t1_p0_data", p0_data_o, RD_LINE);
        tick();
        mem_ack_i = 1'b0; p1_enable_i = 1'b0;
        #1;
        check("t1_turn_grant",   grant_o, 2'b00);
        check("t1_turn_menable", mem_enable_o, 1'b0);

        // Simultaneous requests: port 0 first, then port 1, then port 0 again
        do_reset();
        p0_enable_i = 1'b1; p0_addr_i = 32'h0000_0200;
        p1_enable_i = 1'b1; p1_addr_i = 32'h0000_0300;
        tick(); #1;
        check("t2_first_grant", grant_o, 2'b01);
        check("t2_first_addr",  mem_addr_o, 32'h0000_0200);
        tick();
        mem_ack_i = 1'b1;
        #1;
        check("t2_p0_ack",    p0_ack_o, 1'b1);
        check("t2_p1_noack",  p1_ack_o, 1'b0);
        tick();
        mem_ack_i = 1'b0;   // port 0 re-requests at once
        #1;
        check("t2_k1_grant", grant_o, 2'b00);
        tick(); #1;
        check("t2_k2_grant", grant_o, 2'b00);
        tick(); #1;
        check("t2_k3_grant", grant_o, 2'b10);
        check("t2_k3_addr",  mem_addr_o, 32'h0000_0300);
        tick();
        mem_ack_i = 1'b1;
        #1;
        check("t2_p1_ack",   p1_ack_o, 1'b1);
        check("t2_p0_noack", p0_ack_o, 1'b0);
        tick();
        mem_ack_i = 1'b0; p1_enable_i = 1'b0;
        #1;
        check("t2_turn2_grant", grant_o, 2'b00);
        tick();
        tick(); #1;
        check("t2_third_grant", grant_o, 2'b01);
        tick();
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0; p0_enable_i = 1'b0;

        // Port 1 writeback then read of the same line
        do_reset();
        p1_enable_i = 1'b1; p1_write_i = 1'b1; p1_addr_i = 32'h0000_0400; p1_data_i = WR_LINE;
        tick(); #1;
        check("t3_wr_grant",  grant_o, 2'b10);
        check("t3_wr_mwrite", mem_write_o, 1'b1);
        check("t3_wr_maddr",  mem_addr_o, 32'h0000_0400);
        check("t3_wr_mdata",  mem_data_o, WR_LINE);
        tick();
        mem_ack_i = 1'b1;
        #1;
        check("t3_wr_ack", p1_ack_o, 1'b1);
        tick();
        mem_ack_i = 1'b0; p1_enable_i = 1'b0;
        #1;
        check("t3_turn_mwrite", mem_write_o, 1'b0);
        check("t3_turn_mdata",  mem_data_o, 256'h0);
        tick();
        p1_enable_i = 1'b1; p1_write_i = 1'b0;
        tick(); #1;
        check("t3_rd_grant",  grant_o, 2'b10);
        check("t3_rd_mwrite", mem_write_o, 1'b0);
        check("t3_rd_maddr",  mem_addr_o, 32'h0000_0400);
        tick();
        mem_ack_i = 1'b1; mem_data_i = RD_LINE2;
        #1;
        check("t3_rd_data", p1_data_o, RD_LINE2);
        tick();
        mem_ack_i = 1'b0; p1_enable_i = 1'b0;

        // Port 0 aborts mid-grant; a late ack is dropped
        do_reset();
        p0_enable_i = 1'b1; p0_addr_i = 32'h0000_0500;
        tick(); #1;
        check("t4_grant", grant_o, 2'b01);
        tick();
        p0_enable_i = 1'b0;
        #1;
        check("t4_abort_grant",   grant_o, 2'b01);
        check("t4_abort_menable", mem_enable_o, 1'b0);
        tick();
        mem_ack_i = 1'b1;
        #1;
        check("t4_turn_grant", grant_o, 2'b00);
        check("t4_late_ack",   {p0_ack_o, p1_ack_o}, 2'b00);
        tick();
        mem_ack_i = 1'b0; p0_enable_i = 1'b1;
        #1;
        check("t4_idle_grant", grant_o, 2'b00);
        tick(); #1;
        check("t4_regrant", grant_o, 2'b01);
        p0_enable_i = 1'b0;

        // Watchdog on the TIMEOUT=8 instance
        do_reset();
        p0_enable_i = 1'b1;
        tick(); #1;
        check("t5_grant", wd_grant_o, 2'b01);
        for (int i = 1; i <= 7; i++) begin
            tick(); #1;
            check($sformatf("t5_hold_%0d", i), {wd_grant_o, wd_timeout_o}, {2'b01, 1'b0});
        end
        tick(); #1;
        check("t5_release", wd_grant_o, 2'b00);
        check("t5_timeout", wd_timeout_o, 1'b1);
        check("t5_main_no_timeout", timeout_o, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        #1;
        check("t5_sticky", wd_timeout_o, 1'b1);
        p0_enable_i = 1'b0;
        rst_i = 1'b1;
        tick(); #1;
        check("t5_cleared", wd_timeout_o, 1'b0);
        rst_i = 1'b0;

        // Reset mid-grant drops the grant and restores last = 1
        do_reset();
        p0_enable_i = 1'b1;
        tick(); #1;
        check("t6_grant0", grant_o, 2'b01);
        p1_enable_i = 1'b1; rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
        check("t6_rst_grant",   grant_o, 2'b00);
        check("t6_rst_menable", mem_enable_o, 1'b0);
        tick(); #1;
        check("t6_tie_after_rst", grant_o, 2'b01);
        p0_enable_i = 1'b0; p1_enable_i = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
